// File: rtl/audio_mem_sequencer.sv
// Record/playback sequencer for the SRAM audio-memory port.
// Converts commands and sample strobes into single-cycle access requests.
`timescale 1ns/1ps
module audio_mem_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_start,
  input  logic             i_cmd_pause,
  input  logic             i_cmd_stop,
  input  logic             i_rec,
  input  logic             i_fast,
  input  logic [2:0]       i_speed,
  input  logic             i_sample_stb,
  output logic             o_mem_start,
  output logic             o_mem_mode,
  output logic [2:0]       o_mem_next_num,
  output logic             o_mem_clear,
  input  logic             i_mem_fin,
  input  logic             i_mem_valid,
  output logic             o_hold,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_sample_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  logic             mode_q, mode_d;
  logic             fast_q, fast_d;
  logic [2:0]       speed_q, speed_d;
  logic [2:0]       nn_q, nn_d;
  logic [2:0]       div_q, div_d;
  logic             pend_q, pend_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             clear_q, clear_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             tflag_q, tflag_d;
  logic             slow;
  logic             pend_nxt;

  // Slow playback only divides strobes when speed is above 1x.
  assign slow = (state_q == S_PLAY) && !fast_q && (speed_q != 3'd0);
  assign pend_nxt = pend_q | i_cmd_pause;

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    mode_d  = mode_q;
    fast_d  = fast_q;
    speed_d = speed_q;
    nn_d    = nn_q;
    div_d   = div_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    clear_d = 1'b0;
    hold_d  = 1'b0;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    tflag_d = tflag_q;
    if (i_cmd_stop) begin
      state_d = S_IDLE;
      clear_d = 1'b1;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_cmd_start && !i_cmd_pause) begin
            mode_d  = i_rec;
            fast_d  = i_fast;
            speed_d = i_speed;
            nn_d    = (!i_rec && i_fast) ? i_speed : 3'd0;
            clear_d = 1'b1;
            cnt_d   = '0;
            ovr_d   = 1'b0;
            tflag_d = 1'b0;
            div_d   = 3'd0;
            pend_d  = 1'b0;
            state_d = i_rec ? S_REC : S_PLAY;
            saved_d = i_rec ? S_REC : S_PLAY;
          end
        end
        S_REC, S_PLAY: begin
          if (i_cmd_pause) begin
            state_d = S_PAUSE;
          end else if (i_sample_stb) begin
            if (slow) begin
              div_d = (div_q == speed_q) ? 3'd0 : div_q + 3'd1;
              if (div_q == 3'd0) begin
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
              end else begin
                hold_d = 1'b1;
              end
            end else begin
              start_d = 1'b1;
              tmo_d   = '0;
              state_d = S_WAIT;
            end
          end
        end
        S_PAUSE: begin
          if (i_cmd_start && !i_cmd_pause) state_d = saved_q;
        end
        S_WAIT: begin
          pend_d = pend_nxt;
          if (i_sample_stb) ovr_d = 1'b1;
          if (i_mem_fin) begin
            pend_d = 1'b0;
            if (i_mem_valid) begin
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
              state_d = pend_nxt ? S_PAUSE : saved_q;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            tflag_d = 1'b1;
            pend_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      mode_q  <= 1'b0;
      fast_q  <= 1'b0;
      speed_q <= 3'd0;
      nn_q    <= 3'd0;
      div_q   <= 3'd0;
      pend_q  <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      mode_q  <= mode_d;
      fast_q  <= fast_d;
      speed_q <= speed_d;
      nn_q    <= nn_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      clear_q <= clear_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      tflag_q <= tflag_d;
    end
  end

  assign o_mem_start    = start_q;
  assign o_mem_mode     = mode_q;
  assign o_mem_next_num = nn_q;
  assign o_mem_clear    = clear_q;
  assign o_hold         = hold_q;
  assign o_state        = state_q;
  assign o_done         = done_q;
  assign o_overrun      = ovr_q;
  assign o_timeout      = tflag_q;
  assign o_sample_cnt   = cnt_q;

endmodule
